// File: rtl/multi_cycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle MIPS phase sequencer:
// phase states, opcode/func constants and the instruction-class decode.
package multi_cycle_sequencer_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_JUMP,
        C_BRANCH,
        C_LOAD,
        C_STORE,
        C_HALT
    } iclass_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'b000110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;
    localparam logic [OP_W-1:0] FUNC_JR  = 6'b001000;

    // Unknown opcodes fall into the ALU class.
    function automatic iclass_t classify(input logic [OP_W-1:0] op,
                                         input logic [OP_W-1:0] func);
        iclass_t c;
        c = C_ALU;
        case (op)
            OP_J, OP_JAL:             c = C_JUMP;
            OP_RTYPE:                 c = (func == FUNC_JR) ? C_JUMP : C_ALU;
            OP_BEQ, OP_BNE, OP_BLTZ:  c = C_BRANCH;
            OP_LW:                    c = C_LOAD;
            OP_SW:                    c = C_STORE;
            OP_HALT:                  c = C_HALT;
            default:                  c = C_ALU;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_sequencer_perf_counter.sv
// Free-running event counter with synchronous active-low clear; wraps silently.
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_cycle_sequencer.sv
// Phase controller for the multi-cycle MIPS CPU: steps IF/ID/EXE/MEM/WB and
// gates the decoder's level enables down to single-cycle strobes.
module multi_cycle_sequencer
    import multi_cycle_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             PCWrite_C,
    input  logic             RegWrite_C,
    input  logic             MemWrite_C,
    input  logic             MemRead_C,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             MemRead,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_t  cur;
    state_t  nxt;
    iclass_t cls;
    logic    retire;
    logic    reg_slot;
    logic    mem_slot;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            cur <= S_IF;
        end else begin
            cur <= nxt;
        end
    end

    // Next phase plus the phases in which each strobe may fire.
    always_comb begin
        nxt      = cur;
        retire   = 1'b0;
        reg_slot = 1'b0;
        mem_slot = 1'b0;
        cls      = classify(op, func);
        case (cur)
            S_IF: nxt = S_ID;
            S_ID: begin
                case (cls)
                    C_JUMP: begin
                        nxt      = S_IF;
                        retire   = 1'b1;
                        reg_slot = (op == OP_JAL);
                    end
                    C_HALT:          nxt = S_HALT;
                    C_BRANCH:        nxt = S_EXE_BR;
                    C_LOAD, C_STORE: nxt = S_EXE_LS;
                    default:         nxt = S_EXE_AL;
                endcase
            end
            S_EXE_AL: nxt = S_WB_AL;
            S_WB_AL: begin
                nxt      = S_IF;
                retire   = 1'b1;
                reg_slot = 1'b1;
            end
            S_EXE_BR: begin
                nxt    = S_IF;
                retire = 1'b1;
            end
            S_EXE_LS: nxt = S_MEM;
            S_MEM: begin
                mem_slot = 1'b1;
                if (op == OP_LW) begin
                    nxt = S_WB_LD;
                end else begin
                    nxt    = S_IF;
                    retire = 1'b1;
                end
            end
            S_WB_LD: begin
                nxt      = S_IF;
                retire   = 1'b1;
                reg_slot = 1'b1;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end

    // A low Reset kills every strobe so an abandoned instruction writes nothing.
    assign IRWrite  = Reset && (cur == S_IF);
    assign PCWrite  = Reset && PCWrite_C  && retire;
    assign RegWrite = Reset && RegWrite_C && reg_slot;
    assign MemRead  = Reset && MemRead_C  && mem_slot;
    assign MemWrite = Reset && MemWrite_C && mem_slot;
    assign halted   = (cur == S_HALT);
    assign state    = cur;

    perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk     (CLK),
        .clear_n (Reset),
        .en      (cur != S_HALT),
        .count   (cycle_count)
    );

    perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk     (CLK),
        .clear_n (Reset),
        .en      (PCWrite),
        .count   (instr_count)
    );

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Scoreboard bench: the driver pushes the expected per-cycle response of each
// instruction, a negedge monitor pops and compares against the DUT.
module tb_multi_cycle_sequencer;

    localparam int unsigned CNT_W = 32;

    localparam logic [3:0] L_IF     = 4'b0000;
    localparam logic [3:0] L_ID     = 4'b0001;
    localparam logic [3:0] L_EXE_LS = 4'b0010;
    localparam logic [3:0] L_MEM    = 4'b0011;
    localparam logic [3:0] L_WB_LD  = 4'b0100;
    localparam logic [3:0] L_EXE_BR = 4'b0101;
    localparam logic [3:0] L_EXE_AL = 4'b0110;
    localparam logic [3:0] L_WB_AL  = 4'b0111;
    localparam logic [3:0] L_HALT   = 4'b1000;

    typedef struct packed {
        logic [3:0]       st;
        logic             pcw;
        logic             irw;
        logic             rgw;
        logic             mw;
        logic             mr;
        logic             hlt;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] ins;
    } exp_t;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [5:0]       op;
    logic [5:0]       func;
    logic             PCWrite_C, RegWrite_C, MemWrite_C, MemRead_C;
    logic             PCWrite, IRWrite, RegWrite, MemWrite, MemRead;
    logic [3:0]       state;
    logic             halted;
    logic [CNT_W-1:0] cycle_count, instr_count;

    exp_t             q[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] mcyc = '0;
    logic [CNT_W-1:0] mins = '0;

    multi_cycle_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .op          (op),
        .func        (func),
        .PCWrite_C   (PCWrite_C),
        .RegWrite_C  (RegWrite_C),
        .MemWrite_C  (MemWrite_C),
        .MemRead_C   (MemRead_C),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .state       (state),
        .halted      (halted),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

    // 0 ALU, 1 jump, 2 branch, 3 lw, 4 sw, 5 halt
    function automatic int ref_class(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000010 || o == 6'b000011) return 1;
        if (o == 6'b000000 && f == 6'b001000) return 1;
        if (o == 6'b000100 || o == 6'b000101 || o == 6'b000110) return 2;
        if (o == 6'b100011) return 3;
        if (o == 6'b101011) return 4;
        if (o == 6'b111111) return 5;
        return 0;
    endfunction

    task automatic push(input logic [3:0] st, input logic pcw, input logic rgw,
                        input logic mw, input logic mr);
        exp_t e;
        e.st  = st;
        e.pcw = pcw;
        e.irw = (st == L_IF);
        e.rgw = rgw;
        e.mw  = mw;
        e.mr  = mr;
        e.hlt = (st == L_HALT);
        e.cyc = mcyc;
        e.ins = mins;
        q.push_back(e);
        if (st != L_HALT) mcyc = mcyc + 1;
        if (pcw) mins = mins + 1;
    endtask

    // Runs one instruction; max_ph < phase count truncates it (for reset aborts).
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input logic pc, input logic rw, input logic mw,
                             input logic mr, input int max_ph);
        logic [3:0] ph[$];
        int cls, n, run;
        logic last;
        op = o; func = f;
        PCWrite_C = pc; RegWrite_C = rw; MemWrite_C = mw; MemRead_C = mr;
        cls = ref_class(o, f);
        ph = '{L_IF, L_ID};
        case (cls)
            0: begin ph.push_back(L_EXE_AL); ph.push_back(L_WB_AL); end
            2: ph.push_back(L_EXE_BR);
            3: begin ph.push_back(L_EXE_LS); ph.push_back(L_MEM); ph.push_back(L_WB_LD); end
            4: begin ph.push_back(L_EXE_LS); ph.push_back(L_MEM); end
            default: ;
        endcase
        n = ph.size();
        run = (max_ph > 0 && max_ph < n) ? max_ph : n;
        for (int p = 0; p < run; p++) begin
            last = (p == n - 1) && (cls != 5);
            push(ph[p], pc && last,
                 rw && ((last && (cls == 0 || cls == 3)) || (ph[p] == L_ID && o == 6'b000011)),
                 mw && ph[p] == L_MEM, mr && ph[p] == L_MEM);
        end
        repeat (run) @(posedge CLK);
        #1;
    endtask

    // Holds Reset low for n edges; the first cycle still shows state st0.
    task automatic do_reset(input int n, input logic [3:0] st0, input logic skip_first);
        Reset = 1'b0;
        PCWrite_C = 1'b1; RegWrite_C = 1'b1; MemWrite_C = 1'b1; MemRead_C = 1'b1;
        if (!skip_first) push(st0, 1'b0, 1'b0, 1'b0, 1'b0);
        mcyc = '0; mins = '0;
        for (int i = 1; i < n; i++) begin
            q.push_back('{st: L_IF, pcw: 1'b0, irw: 1'b0, rgw: 1'b0, mw: 1'b0,
                          mr: 1'b0, hlt: 1'b0, cyc: '0, ins: '0});
        end
        repeat (n) @(posedge CLK);
        #1;
        Reset = 1'b1;
    endtask

    task automatic run_halt(input int hold);
        op = 6'b111111; func = 6'($urandom);
        PCWrite_C = 1'b0; RegWrite_C = 1'($urandom);
        MemWrite_C = 1'($urandom); MemRead_C = 1'($urandom);
        push(L_IF, 1'b0, 1'b0, 1'b0, 1'b0);
        push(L_ID, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < hold; i++) push(L_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (hold + 2) @(posedge CLK);
        #1;
        do_reset(2, L_HALT, 1'b0);
    endtask

    task automatic run_random();
        int r;
        logic [5:0] o, f;
        r = $urandom_range(0, 11);
        f = 6'($urandom);
        case (r)
            4:  o = 6'b000010;
            5:  o = 6'b000011;
            6:  begin o = 6'b000000; f = 6'b001000; end
            7:  o = 6'(6'd4 + 6'($urandom_range(0, 2)));
            8, 10: o = 6'b100011;
            9:  o = 6'b101011;
            default: begin
                o = 6'($urandom);
                while (ref_class(o, f) != 0) o = 6'($urandom);
            end
        endcase
        if (r == 11) begin
            run_halt($urandom_range(1, 4));
        end else begin
            run_instr(o, f, 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), (r == 10) ? 3 : 0);
            if (r == 10) do_reset(1, L_MEM, 1'b0);
        end
    endtask

    // Monitor: compares one expected cycle per falling edge while any are queued.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (state !== e.st || PCWrite !== e.pcw || IRWrite !== e.irw ||
                RegWrite !== e.rgw || MemWrite !== e.mw || MemRead !== e.mr ||
                halted !== e.hlt || cycle_count !== e.cyc || instr_count !== e.ins) begin
                n_err++;
                $display("FAIL cycle_vec%0d: got st=%h pc%b ir%b rw%b mw%b mr%b h%b cyc=%0d ins=%0d; want st=%h pc%b ir%b rw%b mw%b mr%b h%b cyc=%0d ins=%0d",
                         n_vec, state, PCWrite, IRWrite, RegWrite, MemWrite, MemRead,
                         halted, cycle_count, instr_count, e.st, e.pcw, e.irw, e.rgw,
                         e.mw, e.mr, e.hlt, e.cyc, e.ins);
            end
        end
    end

    initial begin
        Reset = 1'b0;
        op = '0; func = '0;
        PCWrite_C = 1'b0; RegWrite_C = 1'b0; MemWrite_C = 1'b0; MemRead_C = 1'b0;
        @(posedge CLK);
        #1;
        do_reset(2, L_IF, 1'b1);

        run_instr(6'b000000, 6'b100000, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        run_instr(6'b100011, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        run_instr(6'b101011, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_instr(6'b000011, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run_instr(6'b000000, 6'b001000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_instr(6'b000100, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        run_halt(10);
        run_instr(6'b100011, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 3);
        do_reset(1, L_MEM, 1'b0);
        run_instr(6'b000000, 6'b100000, 1'b1, 1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 150; i++) run_random();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge CLK);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d expected cycles unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
